// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch
// Purpose  : Instruction-fetch front end. Issues one word read per PC over a
//            valid/ready channel (at most one in flight) and registers the
//            returned instruction and its PC into the IF/ID slot.
//            Optional build macro IMEM_FETCH_MISALIGN_EN adds misaligned-PC
//            fault reporting on misalign_o.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        stallD,
    input  logic        flushD,
    output logic        stallF_o,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    output logic        imem_rsp_ready,
    input  logic [31:0] imem_rsp_data,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_d_o
`ifdef IMEM_FETCH_MISALIGN_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_d_q,  pc_d_d;
    logic [31:0] req_pc_q, req_pc_d;
`ifdef IMEM_FETCH_MISALIGN_EN
    logic        misalign_q, misalign_d;
`endif

    logic w_rsp_ready;
    logic w_rsp_hs;
    logic w_slot_free;
    logic w_issue_pt;
    logic w_misalign;
    logic w_req_valid;
    logic w_req_acc;
    logic w_fault_take;

    // Handshake and issue decisions
    always_comb begin
        w_rsp_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                S_WAIT:  w_rsp_ready = !valid_q || !stallD;
                S_DROP:  w_rsp_ready = 1'b1;
                default: w_rsp_ready = 1'b0;
            endcase
        end
        w_rsp_hs    = imem_rsp_valid && w_rsp_ready;
        w_slot_free = !valid_q || !stallD || (state_q == S_DROP);
        w_issue_pt  = !rst && !flushD && w_slot_free &&
                      ((state_q == S_IDLE) ||
                       (((state_q == S_WAIT) || (state_q == S_DROP)) && w_rsp_hs));
`ifdef IMEM_FETCH_MISALIGN_EN
        w_misalign   = (pc_i[1:0] != 2'b00);
        // A WAIT response claims the slot this cycle; the fault is reported
        // from IDLE on the following cycle instead.
        w_fault_take = w_issue_pt && w_misalign && (state_q != S_WAIT);
`else
        w_misalign   = 1'b0;
        w_fault_take = 1'b0;
`endif
        w_req_valid = w_issue_pt && !w_misalign;
        w_req_acc   = w_req_valid && imem_req_ready;
    end

    // Next state
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        if (w_req_acc) begin
            req_pc_d = pc_i;
        end
        case (state_q)
            S_IDLE: begin
                if (w_req_acc) begin
                    state_d = S_WAIT;
                end else if (w_fault_take) begin
                    state_d = S_FAULT;
                end
            end
            S_WAIT: begin
                if (flushD) begin
                    state_d = w_rsp_hs ? S_IDLE : S_DROP;
                end else if (w_rsp_hs) begin
                    state_d = w_req_acc ? S_WAIT : S_IDLE;
                end
            end
            S_DROP: begin
                if (w_rsp_hs) begin
                    if (w_req_acc) begin
                        state_d = S_WAIT;
                    end else if (w_fault_take) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef IMEM_FETCH_MISALIGN_EN
            S_FAULT: begin
                if (flushD) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // IF/ID output slot
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d_d  = pc_d_q;
`ifdef IMEM_FETCH_MISALIGN_EN
        misalign_d = misalign_q;
`endif
        if (flushD) begin
            valid_d = 1'b0;
`ifdef IMEM_FETCH_MISALIGN_EN
            misalign_d = 1'b0;
`endif
        end else if ((state_q == S_WAIT) && w_rsp_hs) begin
            valid_d = 1'b1;
            instr_d = imem_rsp_data;
            pc_d_d  = req_pc_q;
        end else if (w_fault_take) begin
            valid_d = 1'b1;
            instr_d = NOP_INSTR;
            pc_d_d  = pc_i;
`ifdef IMEM_FETCH_MISALIGN_EN
            misalign_d = 1'b1;
`endif
        end else if (valid_q && !stallD) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc_d_q   <= RESET_VECTOR;
            req_pc_q <= 32'h0;
`ifdef IMEM_FETCH_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc_d_q   <= pc_d_d;
            req_pc_q <= req_pc_d;
`ifdef IMEM_FETCH_MISALIGN_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = {pc_i[31:2], 2'b00};
    assign imem_rsp_ready = w_rsp_ready;
    assign stallF_o       = !w_req_acc;
    assign valid_o        = valid_q;
    assign instr_o        = valid_q ? instr_q : NOP_INSTR;
    assign pc_d_o         = pc_d_q;
`ifdef IMEM_FETCH_MISALIGN_EN
    assign misalign_o     = misalign_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch
// Purpose  : Cycle-by-cycle directed vectors for imem_fetch; the bench plays
//            the PC register and memory by hand. Misalign checks run only
//            when IMEM_FETCH_MISALIGN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch;

    localparam logic [31:0] RV  = 32'h1000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = 32'h0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        stallF_o;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_d_o;
`ifdef IMEM_FETCH_MISALIGN_EN
    logic        misalign_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_fetch #(
        .RESET_VECTOR (RV),
        .NOP_INSTR    (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .stallD         (stallD),
        .flushD         (flushD),
        .stallF_o       (stallF_o),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_data  (imem_rsp_data),
        .valid_o        (valid_o),
        .instr_o        (instr_o),
        .pc_d_o         (pc_d_o)
`ifdef IMEM_FETCH_MISALIGN_EN
        ,
        .misalign_o     (misalign_o)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic        rst, std, fld, rdy, rspv;
        logic [31:0] data;
        logic        rv, sf, rr, vo;
        logic [31:0] ins, pcd;
    } vec_t;

    // ctl = {rst, stallD, flushD, req_ready, rsp_valid}; ex = {req_valid, stallF, rsp_ready, valid_o}
    function automatic vec_t v(input logic [31:0] pc, input logic [4:0] ctl,
                               input logic [31:0] data, input logic [3:0] ex,
                               input logic [31:0] ins, input logic [31:0] pcd);
        vec_t r;
        r.pc = pc;
        {r.rst, r.std, r.fld, r.rdy, r.rspv} = ctl;
        r.data = data;
        {r.rv, r.sf, r.rr, r.vo} = ex;
        r.ins = ins;
        r.pcd = pcd;
        return r;
    endfunction

    task automatic chk(input string what, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", what, idx, act, exp);
        end
    endtask

    task automatic cycle(input string tag, input int idx, input vec_t x);
        logic [31:0] exp_addr;
        @(posedge clk);
        #1;
        rst            = x.rst;
        pc_i           = x.pc;
        stallD         = x.std;
        flushD         = x.fld;
        imem_req_ready = x.rdy;
        imem_rsp_valid = x.rspv;
        imem_rsp_data  = x.data;
        @(negedge clk);
        chk({tag, ".req_valid"}, idx, 32'(imem_req_valid), 32'(x.rv));
        chk({tag, ".stallF"},    idx, 32'(stallF_o),       32'(x.sf));
        chk({tag, ".rsp_ready"}, idx, 32'(imem_rsp_ready), 32'(x.rr));
        chk({tag, ".valid_o"},   idx, 32'(valid_o),        32'(x.vo));
        chk({tag, ".instr_o"},   idx, instr_o,             x.ins);
        chk({tag, ".pc_d_o"},    idx, pc_d_o,              x.pcd);
        if (x.rv) begin
            exp_addr = {x.pc[31:2], 2'b00};
            chk({tag, ".req_addr"}, idx, imem_req_addr, exp_addr);
        end
    endtask

    localparam int NV = 24;
    vec_t vecs [NV];

    initial begin
        // reset, streaming, request backpressure, decode stall, flush cases
        vecs[0]  = v(32'h0,   5'b10010, 32'h0,        4'b0100, NOP, RV);
        vecs[1]  = v(32'h0,   5'b10010, 32'h0,        4'b0100, NOP, RV);
        vecs[2]  = v(32'h0,   5'b00010, 32'h0,        4'b1000, NOP, RV);
        vecs[3]  = v(32'h4,   5'b00011, 32'h00500093, 4'b1010, NOP, RV);
        vecs[4]  = v(32'h8,   5'b00011, 32'h00100113, 4'b1011, 32'h00500093, 32'h0);
        vecs[5]  = v(32'hC,   5'b00011, 32'h00200193, 4'b1011, 32'h00100113, 32'h4);
        vecs[6]  = v(32'h10,  5'b00001, 32'h00300213, 4'b1111, 32'h00200193, 32'h8);
        vecs[7]  = v(32'h10,  5'b00000, 32'h0,        4'b1101, 32'h00300213, 32'hC);
        vecs[8]  = v(32'h10,  5'b00000, 32'h0,        4'b1100, NOP, 32'hC);
        vecs[9]  = v(32'h10,  5'b00010, 32'h0,        4'b1000, NOP, 32'hC);
        vecs[10] = v(32'h14,  5'b00010, 32'h0,        4'b0110, NOP, 32'hC);
        vecs[11] = v(32'h14,  5'b00011, 32'h00400293, 4'b1010, NOP, 32'hC);
        vecs[12] = v(32'h18,  5'b01011, 32'h00500313, 4'b0101, 32'h00400293, 32'h10);
        vecs[13] = v(32'h18,  5'b01011, 32'h00500313, 4'b0101, 32'h00400293, 32'h10);
        vecs[14] = v(32'h18,  5'b00011, 32'h00500313, 4'b1011, 32'h00400293, 32'h10);
        vecs[15] = v(32'h1C,  5'b00010, 32'h0,        4'b0111, 32'h00500313, 32'h14);
        vecs[16] = v(32'h1C,  5'b00110, 32'h0,        4'b0110, NOP, 32'h14);
        vecs[17] = v(32'h100, 5'b00010, 32'h0,        4'b0110, NOP, 32'h14);
        vecs[18] = v(32'h100, 5'b00011, 32'hDEADBEEF, 4'b1010, NOP, 32'h14);
        vecs[19] = v(32'h104, 5'b00011, 32'h00600393, 4'b1010, NOP, 32'h14);
        vecs[20] = v(32'h108, 5'b01111, 32'h00700413, 4'b0101, 32'h00600393, 32'h100);
        vecs[21] = v(32'h200, 5'b00011, 32'h00700413, 4'b1010, NOP, 32'h100);
        vecs[22] = v(32'h204, 5'b00011, 32'h00800493, 4'b1010, NOP, 32'h100);
        vecs[23] = v(32'h208, 5'b00010, 32'h0,        4'b0111, 32'h00800493, 32'h200);

        for (int i = 0; i < NV; i++) begin
            cycle("vec", i, vecs[i]);
        end

        // flush while the WAIT response handshakes: response discarded, IDLE
        cycle("flush_rsp", 0, v(32'h208, 5'b00111, 32'hBAD0BAD0, 4'b0110, NOP, 32'h200));
        cycle("flush_rsp", 1, v(32'h300, 5'b00010, 32'h0,        4'b1000, NOP, 32'h200));

        // reset with a request outstanding; stale response is not accepted
        cycle("mid_rst", 0, v(32'h304, 5'b10011, 32'h11111111, 4'b0100, NOP, 32'h200));
        cycle("mid_rst", 1, v(32'h400, 5'b00001, 32'h11111111, 4'b1100, NOP, RV));
        cycle("mid_rst", 2, v(32'h400, 5'b00000, 32'h0,        4'b1100, NOP, RV));

`ifdef IMEM_FETCH_MISALIGN_EN
        cycle("misalign", 0, v(32'h102, 5'b00010, 32'h0, 4'b0100, NOP, RV));
        chk("misalign_o", 0, 32'(misalign_o), 32'd0);
        cycle("misalign", 1, v(32'h102, 5'b00010, 32'h0, 4'b0101, NOP, 32'h102));
        chk("misalign_o", 1, 32'(misalign_o), 32'd1);
        cycle("misalign", 2, v(32'h102, 5'b00010, 32'h0, 4'b0100, NOP, 32'h102));
        chk("misalign_o", 2, 32'(misalign_o), 32'd1);
        cycle("misalign", 3, v(32'h500, 5'b00110, 32'h0, 4'b0100, NOP, 32'h102));
        chk("misalign_o", 3, 32'(misalign_o), 32'd1);
        cycle("misalign", 4, v(32'h500, 5'b00010, 32'h0, 4'b1000, NOP, 32'h102));
        chk("misalign_o", 4, 32'(misalign_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
